game_step_sequencer: RTL and testbench
======================================

Name: game_step_sequencer

Overview:
- Sequences one snake update per game_tik from the speed-level tick generator.
- Issues ordered request/done handshakes to the snake datapath units: head move, collision check, food check, tail removal.
- Holds the committed direction, score, step count, game-over state and a frame-overrun flag.
- Sits between the tick generator and the snake body/food units; all work must finish while frame_tik is high (vertical front porch).

Parameters:
- TIMEOUT_CYCLES, 4000: per-phase watchdog limit in clock_25 cycles.
- SCORE_W, 8: score width; score saturates at all-ones.
- STEP_W, 16: step counter width; counter wraps.

Ports:
- clock_25  in  1  25 MHz system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  game enable level
- game_tik  in  1  one-cycle step pulse
- frame_tik  in  1  high during vertical front porch
- btn_up, btn_right, btn_down, btn_left  in  1 each  synchronized one-cycle direction pulses
- head_done  in  1  head unit finished
- coll_done  in  1  collision unit finished
- coll_hit  in  1  collision result, valid with coll_done
- food_done  in  1  food unit finished
- food_eaten  in  1  food result, valid with food_done
- tail_done  in  1  tail unit finished
- head_req, coll_req, food_req, tail_req  out  1 each  one-cycle request pulses
- dir  out  2  committed direction: 00 up, 01 right, 10 down, 11 left
- busy  out  1  step in progress
- game_over  out  1  collision or fault
- fault  out  1  watchdog expiry
- overrun  out  1  sticky; step missed its frame window
- score  out  SCORE_W  food count
- step_count  out  STEP_W  completed steps

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE; all req outputs, busy, game_over, fault, overrun = 0.
  - score = 0, step_count = 0; dir = 01, pending_dir = 01.
- Direction capture, every cycle:
  - Button pulse updates pending_dir.
  - Priority when several pulses coincide: up > right > down > left.
  - A request for the exact reverse of the committed dir is discarded.
- States:
  - IDLE: counters, flags and pending_dir cleared to reset values. start=1 -> WAIT_TIK.
  - WAIT_TIK: start=0 -> IDLE; else game_tik=1 -> LATCH.
  - LATCH: dir <= pending_dir; busy <= 1; -> HEAD.
  - HEAD: head_req=1 in the first cycle only; head_done sampled from the second cycle; done -> COLL.
  - COLL: coll_req pulse as in HEAD. On done: coll_hit=1 -> OVER, else -> FOOD.
  - FOOD: food_req pulse. On done: food_eaten=1 -> score+1 (saturating) and -> DONE, skipping TAIL (growth); else -> TAIL.
  - TAIL: tail_req pulse; tail_done -> DONE.
  - DONE: step_count+1 (wraps); busy <= 0; start=0 -> IDLE, else -> WAIT_TIK.
  - OVER: game_over=1, busy=0; held until start=0 -> IDLE.
- Request timing:
  - All req outputs are registered, so they appear one cycle after state entry.
  - A done asserted in the same cycle as the req is ignored.
  - Minimum step with food eaten is 8 cycles from the game_tik edge to busy=0.
- start=0 mid-step: the step completes normally; the exit is taken at DONE.
- Overrun sets (sticky until IDLE) on either event:
  - frame_tik 1->0 while busy=1;
  - game_tik=1 while busy=1 (that pulse is dropped).
- Unused state encodings -> IDLE.

Optional Feature:
- Macro: GAME_STEP_WATCHDOG_EN.
- Defined:
  - Per-phase counter resets on every phase entry.
  - If done is not received after TIMEOUT_CYCLES cycles: fault=1, -> OVER.
  - fault clears only in IDLE.
- Undefined: no counter; phases wait indefinitely; fault tied to 0.

Test Plan:
- Reset, start=1, game_tik pulse, each done returned 2 cycles after its req, coll_hit=0, food_eaten=0:
  - req order head, coll, food, tail; step_count=1, score=0, dir=01, busy back to 0.
- dir=01, btn_left then btn_up pulses before game_tik:
  - left rejected (reverse); after LATCH dir=00.
- Two steps with food_eaten=1:
  - no tail_req in either; score=2.
  - With SCORE_W=2 and 5 eats, score stays 3.
- coll_hit=1 on the first step:
  - game_over=1, no food_req.
  - Further game_tik ignored; start=0 -> IDLE clears game_over, score and step_count.
- frame_tik falls while waiting for food_done, and a second game_tik arrives during the same step:
  - overrun=1; step_count increments only once.
- GAME_STEP_WATCHDOG_EN defined, TIMEOUT_CYCLES=16, head_done never asserted:
  - fault=1 and game_over=1 by cycle 17 after head_req.
  - Macro undefined: busy stays 1 indefinitely.

Source files
------------

// File: rtl/game_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : game_step_sequencer
// Purpose  : Runs one snake update per game_tik. It sends ordered req/done
//            handshakes to the head, collision, food and tail units. It holds
//            the committed direction, score, step count, game-over and the
//            sticky frame-overrun flag.
// Ports    : clock_25 / reset (async, active-low)
//            start, game_tik, frame_tik          - game control and timing
//            btn_up/right/down/left              - one-cycle direction pulses
//            *_done, coll_hit, food_eaten        - datapath unit responses
//            head/coll/food/tail_req             - one-cycle request pulses
//            dir, busy, game_over, fault, overrun, score, step_count
// Options  : GAME_STEP_WATCHDOG_EN - per-phase timeout (TIMEOUT_CYCLES) that
//            raises fault and ends the game; without it, fault is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module game_step_sequencer #(
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int SCORE_W        = 8,
    parameter int STEP_W         = 16
) (
    input  logic               clock_25,
    input  logic               reset,
    input  logic               start,
    input  logic               game_tik,
    input  logic               frame_tik,
    input  logic               btn_up,
    input  logic               btn_right,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               head_done,
    input  logic               coll_done,
    input  logic               coll_hit,
    input  logic               food_done,
    input  logic               food_eaten,
    input  logic               tail_done,
    output logic               head_req,
    output logic               coll_req,
    output logic               food_req,
    output logic               tail_req,
    output logic [1:0]         dir,
    output logic               busy,
    output logic               game_over,
    output logic               fault,
    output logic               overrun,
    output logic [SCORE_W-1:0] score,
    output logic [STEP_W-1:0]  step_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_TIK = 4'd1,
        S_LATCH    = 4'd2,
        S_HEAD     = 4'd3,
        S_COLL     = 4'd4,
        S_FOOD     = 4'd5,
        S_TAIL     = 4'd6,
        S_DONE     = 4'd7,
        S_OVER     = 4'd8
    } state_t;

    localparam logic [1:0] c_dir_up    = 2'b00;
    localparam logic [1:0] c_dir_right = 2'b01;
    localparam logic [1:0] c_dir_down  = 2'b10;
    localparam logic [1:0] c_dir_left  = 2'b11;

    state_t             state_q, state_d;
    logic               head_req_q, head_req_d, coll_req_q, coll_req_d;
    logic               food_req_q, food_req_d, tail_req_q, tail_req_d;
    logic [1:0]         dir_q, dir_d, pending_dir_q, pending_dir_d;
    logic               busy_q, busy_d, game_over_q, game_over_d;
    logic               overrun_q, overrun_d, frame_prev_q, frame_prev_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               w_btn_valid;
    logic [1:0]         w_btn_dir;
    logic               w_phase_first;

`ifdef GAME_STEP_WATCHDOG_EN
    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0]            wd_cnt_q, wd_cnt_d;
    logic                       fault_q, fault_d;
    logic                       w_in_phase;
`endif

    // Fixed button priority: up > right > down > left.
    always_comb begin
        w_btn_valid = btn_up | btn_right | btn_down | btn_left;
        if (btn_up)          w_btn_dir = c_dir_up;
        else if (btn_right)  w_btn_dir = c_dir_right;
        else if (btn_down)   w_btn_dir = c_dir_down;
        else                 w_btn_dir = c_dir_left;
    end

    // A request is high only in the first cycle of its phase. A done seen in
    // that same cycle belongs to nothing we asked for, so it is ignored.
    assign w_phase_first = head_req_q | coll_req_q | food_req_q | tail_req_q;

    always_comb begin
        state_d       = state_q;
        head_req_d    = 1'b0;
        coll_req_d    = 1'b0;
        food_req_d    = 1'b0;
        tail_req_d    = 1'b0;
        dir_d         = dir_q;
        pending_dir_d = pending_dir_q;
        busy_d        = busy_q;
        game_over_d   = game_over_q;
        overrun_d     = overrun_q;
        score_d       = score_q;
        step_d        = step_q;
        frame_prev_d  = frame_tik;
`ifdef GAME_STEP_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q + WD_W'(1);
        fault_d       = fault_q;
        w_in_phase    = 1'b0;
`endif

        // The step overran its window: the front porch ended, or the next tick
        // arrived before this step finished. That tick is simply not consumed.
        if (busy_q && ((frame_prev_q && !frame_tik) || game_tik)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                dir_d         = c_dir_right;
                pending_dir_d = c_dir_right;
                busy_d        = 1'b0;
                game_over_d   = 1'b0;
                overrun_d     = 1'b0;
                score_d       = '0;
                step_d        = '0;
`ifdef GAME_STEP_WATCHDOG_EN
                fault_d       = 1'b0;
`endif
                if (start) state_d = S_WAIT_TIK;
            end
            S_WAIT_TIK: begin
                if (!start)        state_d = S_IDLE;
                else if (game_tik) state_d = S_LATCH;
            end
            S_LATCH: begin
                dir_d      = pending_dir_q;
                busy_d     = 1'b1;
                head_req_d = 1'b1;
                state_d    = S_HEAD;
            end
            S_HEAD: begin
                if (!w_phase_first && head_done) begin
                    coll_req_d = 1'b1;
                    state_d    = S_COLL;
                end
            end
            S_COLL: begin
                if (!w_phase_first && coll_done) begin
                    if (coll_hit) begin
                        game_over_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_OVER;
                    end else begin
                        food_req_d  = 1'b1;
                        state_d     = S_FOOD;
                    end
                end
            end
            S_FOOD: begin
                if (!w_phase_first && food_done) begin
                    if (food_eaten) begin
                        // Growth: keep the tail this step.
                        if (score_q != '1) score_d = score_q + SCORE_W'(1);
                        state_d = S_DONE;
                    end else begin
                        tail_req_d = 1'b1;
                        state_d    = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (!w_phase_first && tail_done) state_d = S_DONE;
            end
            S_DONE: begin
                step_d  = step_q + STEP_W'(1);
                busy_d  = 1'b0;
                state_d = start ? S_WAIT_TIK : S_IDLE;
            end
            S_OVER: begin
                busy_d = 1'b0;
                if (!start) state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Check for reversal against the direction that will be committed
        // after this edge, so a press in the LATCH cycle cannot queue a U-turn.
        if (state_q != S_IDLE && w_btn_valid && (w_btn_dir != (dir_d ^ 2'b10))) begin
            pending_dir_d = w_btn_dir;
        end

`ifdef GAME_STEP_WATCHDOG_EN
        w_in_phase = (state_q == S_HEAD) || (state_q == S_COLL) ||
                     (state_q == S_FOOD) || (state_q == S_TAIL);
        if (!w_in_phase || (state_d != state_q)) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q == c_wd_last) begin
            fault_d     = 1'b1;
            game_over_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_OVER;
        end
`endif
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            head_req_q    <= 1'b0;
            coll_req_q    <= 1'b0;
            food_req_q    <= 1'b0;
            tail_req_q    <= 1'b0;
            dir_q         <= c_dir_right;
            pending_dir_q <= c_dir_right;
            busy_q        <= 1'b0;
            game_over_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_prev_q  <= 1'b0;
            score_q       <= '0;
            step_q        <= '0;
`ifdef GAME_STEP_WATCHDOG_EN
            wd_cnt_q      <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            head_req_q    <= head_req_d;
            coll_req_q    <= coll_req_d;
            food_req_q    <= food_req_d;
            tail_req_q    <= tail_req_d;
            dir_q         <= dir_d;
            pending_dir_q <= pending_dir_d;
            busy_q        <= busy_d;
            game_over_q   <= game_over_d;
            overrun_q     <= overrun_d;
            frame_prev_q  <= frame_prev_d;
            score_q       <= score_d;
            step_q        <= step_d;
`ifdef GAME_STEP_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            fault_q       <= fault_d;
`endif
        end
    end

    assign head_req   = head_req_q;
    assign coll_req   = coll_req_q;
    assign food_req   = food_req_q;
    assign tail_req   = tail_req_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign game_over  = game_over_q;
    assign overrun    = overrun_q;
    assign score      = score_q;
    assign step_count = step_q;
`ifdef GAME_STEP_WATCHDOG_EN
    assign fault      = fault_q;
`else
    assign fault      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_game_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_step_sequencer
// Purpose  : Directed, self-checking bench for game_step_sequencer. A responder
//            answers each request after resp_delay cycles. A scoreboard queue
//            holds the request order that each step is expected to produce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_game_step_sequencer;

    localparam int SCORE_W_TB = 2;
    localparam int STEP_W_TB  = 4;
    localparam int TIMEOUT_TB = 16;

    logic                  clock_25 = 1'b0;
    logic                  reset    = 1'b1;
    logic                  start = 1'b0, game_tik = 1'b0, frame_tik = 1'b1;
    logic                  btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
    logic                  head_done = 1'b0, coll_done = 1'b0, coll_hit = 1'b0;
    logic                  food_done = 1'b0, food_eaten = 1'b0, tail_done = 1'b0;
    logic                  head_req, coll_req, food_req, tail_req;
    logic [1:0]            dir;
    logic                  busy, game_over, fault, overrun;
    logic [SCORE_W_TB-1:0] score;
    logic [STEP_W_TB-1:0]  step_count;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_q[$];
    int         resp_delay   = 2;
    bit         resp_head_en = 1'b1;
    bit         eat_v = 1'b0, hit_v = 1'b0;
    int         pend_cnt = 0;
    logic [3:0] pend_kind = '0;
    logic [3:0] mon_obs, mon_exp;
    int         cyc, n;

    game_step_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT_TB),
        .SCORE_W        (SCORE_W_TB),
        .STEP_W         (STEP_W_TB)
    ) dut (
        .clock_25   (clock_25),
        .reset      (reset),
        .start      (start),
        .game_tik   (game_tik),
        .frame_tik  (frame_tik),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .head_done  (head_done),
        .coll_done  (coll_done),
        .coll_hit   (coll_hit),
        .food_done  (food_done),
        .food_eaten (food_eaten),
        .tail_done  (tail_done),
        .head_req   (head_req),
        .coll_req   (coll_req),
        .food_req   (food_req),
        .tail_req   (tail_req),
        .dir        (dir),
        .busy       (busy),
        .game_over  (game_over),
        .fault      (fault),
        .overrun    (overrun),
        .score      (score),
        .step_count (step_count)
    );

    always #20 clock_25 = ~clock_25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Responder and request monitor, sampled 1 time unit after each rising edge.
    always begin
        @(posedge clock_25);
        #1;
        head_done  = 1'b0; coll_done = 1'b0; coll_hit = 1'b0;
        food_done  = 1'b0; food_eaten = 1'b0; tail_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                head_done  = pend_kind[0] && resp_head_en;
                coll_done  = pend_kind[1];
                coll_hit   = pend_kind[1] && hit_v;
                food_done  = pend_kind[2];
                food_eaten = pend_kind[2] && eat_v;
                tail_done  = pend_kind[3];
            end
        end
        mon_obs = {tail_req, food_req, coll_req, head_req};
        if (mon_obs != 4'b0000) begin
            mon_exp = 4'b0000;
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            chk("req_order", 32'(mon_obs), 32'(mon_exp));
            pend_kind = mon_obs;
            pend_cnt  = resp_delay;
        end
    end

    // Cycles from the edge that samples game_tik to busy falling back to 0.
    function automatic int step_len(input bit eat, input bit hit, input int d);
        int phases;
        phases = hit ? 2 : (eat ? 3 : 4);
        return hit ? (1 + phases * (d + 1)) : (2 + phases * (d + 1));
    endfunction

    task automatic run_tik(output int c);
        bit seen;
        game_tik = 1'b1;
        @(negedge clock_25);
        game_tik = 1'b0;
        c = 0;
        seen = 1'b0;
        while (c < 300) begin
            @(negedge clock_25);
            c++;
            if (busy === 1'b1) seen = 1'b1;
            else if (seen) break;
        end
    endtask

    task automatic push_step(input bit eat, input bit hit);
        eat_v = eat;
        hit_v = hit;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        if (!hit)         exp_q.push_back(4'b0100);
        if (!hit && !eat) exp_q.push_back(4'b1000);
    endtask

    task automatic do_step(input string tag, input bit eat, input bit hit);
        int c;
        push_step(eat, hit);
        run_tik(c);
        chk({tag, "_latency"}, c, step_len(eat, hit, resp_delay));
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_busy_low();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clock_25);
            k++;
        end
        chk("busy_low_timeout", (k < 200), 1);
    endtask

    task automatic wait_food_req();
        int k;
        k = 0;
        while (food_req !== 1'b1 && k < 60) begin
            @(negedge clock_25);
            k++;
        end
        chk("food_req_seen", (k < 60), 1);
    endtask

    initial begin
        #5 reset = 1'b0;
        repeat (2) @(negedge clock_25);
        chk("rst_dir", dir, 2'b01);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {game_over, fault, overrun}, 0);
        chk("rst_counts", {score, step_count}, 0);
        chk("rst_reqs", {head_req, coll_req, food_req, tail_req}, 0);
        reset = 1'b1;
        @(negedge clock_25);
        start = 1'b1;
        repeat (2) @(negedge clock_25);

        // Plain step, responses two cycles after each request.
        do_step("step1", 1'b0, 1'b0);
        chk("step1_count", step_count, 1);
        chk("step1_score", score, 0);
        chk("step1_dir", dir, 2'b01);
        chk("step1_busy", busy, 0);

        // Left is the reverse of right and is dropped; up is then accepted.
        btn_left = 1'b1; @(negedge clock_25); btn_left = 1'b0;
        btn_up   = 1'b1; @(negedge clock_25); btn_up   = 1'b0;
        chk("dir_not_yet_committed", dir, 2'b01);
        do_step("step_up", 1'b0, 1'b0);
        chk("dir_up", dir, 2'b00);
        btn_down = 1'b1; @(negedge clock_25); btn_down = 1'b0;
        do_step("step_rev", 1'b0, 1'b0);
        chk("dir_reverse_dropped", dir, 2'b00);
        btn_right = 1'b1; btn_left = 1'b1; @(negedge clock_25);
        btn_right = 1'b0; btn_left = 1'b0;
        do_step("step_prio", 1'b0, 1'b0);
        chk("dir_priority_right", dir, 2'b01);
        chk("count_after_4", step_count, 4);

        // Two eats: no tail requests, score 2.
        do_step("eat1", 1'b1, 1'b0);
        do_step("eat2", 1'b1, 1'b0);
        chk("score_two", score, 2);
        // Fastest possible step with food eaten.
        resp_delay = 1;
        do_step("eat_min", 1'b1, 1'b0);
        chk("score_three", score, 3);
        for (int i = 0; i < 14; i++) do_step("eat_sat", 1'b1, 1'b0);
        chk("score_saturated", score, 3);
        chk("count_wrapped", step_count, (7 + 14) % 16);
        resp_delay = 2;

        // Collision ends the game; further ticks are ignored.
        do_step("coll", 1'b0, 1'b1);
        chk("coll_game_over", game_over, 1);
        chk("coll_count_held", step_count, 5);
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        repeat (10) @(negedge clock_25);
        chk("over_tik_ignored", {game_over, busy, overrun}, 3'b100);
        start = 1'b0;
        repeat (2) @(negedge clock_25);
        chk("idle_game_over", game_over, 0);
        chk("idle_counts", {score, step_count}, 0);
        chk("idle_dir", dir, 2'b01);

        // Overrun from frame_tik falling mid-step.
        start = 1'b1;
        repeat (2) @(negedge clock_25);
        push_step(1'b0, 1'b0);
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        wait_food_req();
        chk("ovr_clear_before", overrun, 0);
        frame_tik = 1'b0;
        wait_busy_low();
        frame_tik = 1'b1;
        chk("ovr_frame", overrun, 1);
        chk("ovr_frame_count", step_count, 1);
        chk("ovr_frame_drained", exp_q.size(), 0);
        start = 1'b0;
        repeat (2) @(negedge clock_25);
        chk("ovr_cleared_idle", overrun, 0);

        // Overrun from a second tick mid-step; that tick starts nothing.
        start = 1'b1;
        repeat (2) @(negedge clock_25);
        push_step(1'b0, 1'b0);
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        wait_food_req();
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        wait_busy_low();
        repeat (20) @(negedge clock_25);
        chk("ovr_tik", overrun, 1);
        chk("ovr_tik_count_once", step_count, 1);
        chk("ovr_tik_drained", exp_q.size(), 0);

        // start dropped mid-step: step finishes, then exit to IDLE.
        push_step(1'b0, 1'b0);
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        @(negedge clock_25);
        start = 1'b0;
        wait_busy_low();
        chk("stop_mid_count", step_count, 2);
        chk("stop_mid_drained", exp_q.size(), 0);
        @(negedge clock_25);
        chk("stop_mid_idle", step_count, 0);

        // Head unit never answers.
        start = 1'b1;
        repeat (2) @(negedge clock_25);
        resp_head_en = 1'b0;
        exp_q.push_back(4'b0001);
        game_tik = 1'b1; @(negedge clock_25); game_tik = 1'b0;
        n = 0;
        while (head_req !== 1'b1 && n < 10) begin
            @(negedge clock_25);
            n++;
        end
        chk("hang_head_req_seen", (n < 10), 1);
`ifdef GAME_STEP_WATCHDOG_EN
        n = 0;
        while (fault !== 1'b1 && n < 17) begin
            @(negedge clock_25);
            n++;
        end
        chk("wd_fault", fault, 1);
        chk("wd_game_over", game_over, 1);
        chk("wd_busy", busy, 0);
`else
        repeat (100) @(negedge clock_25);
        chk("hang_busy_held", busy, 1);
        chk("hang_no_fault", fault, 0);
`endif
        resp_head_en = 1'b1;

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clock_25);
        #5 reset = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_flags", {game_over, fault, overrun}, 0);
        chk("async_rst_dir", dir, 2'b01);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock_25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
